// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types and helpers for the time-shared adder arbiter
package adder_share_pkg;
  localparam int WIDTH_DEF = 6;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_req
);
  logic [NUM_REQ-1:0] rot;
  logic [IDW:0] off, pos;
  assign any_req = |req;
  assign grant = any_req ? NUM_REQ'(1) << grant_idx : '0;
  // rotate requests so ptr sits at bit 0, take the lowest set bit, then map back
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = (IDW+1)'(k);
    pos = {1'b0, ptr} + off;
    grant_idx = IDW'(pos >= (IDW+1)'(NUM_REQ) ? pos - (IDW+1)'(NUM_REQ) : pos);
  end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin time-sharing of one adder between several requesters
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW = idw(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     busy
);
  state_t state;
  logic [IDW-1:0] rr_ptr, cur_id, gidx;
  logic [NUM_REQ-1:0] grant;
  logic any_req;
  logic [WIDTH-1:0] a_q, b_q, sum;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(grant), .grant_idx(gidx), .any_req(any_req)
  );
  assign sum = a_q + b_q;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  // grant/latch in IDLE, one full cycle for the ripple add, hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_sum <= '0;
      rsp_id <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          a_q <= req_a[gidx*WIDTH +: WIDTH];
          b_q <= req_b[gidx*WIDTH +: WIDTH];
          cur_id <= gidx;
          state <= CALC;
        end
        CALC: begin
          rsp_sum <= sum;
          rsp_id <= cur_id;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= (cur_id == IDW'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed self-checking bench for adder_share_arb
module tb_adder_share_arb;
  localparam int N = 4;
  localparam int W = 6;
  logic clk, rst, rsp_valid, rsp_ready, busy;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_sum;
  int tests, fails;
  int gcyc[$];
  int gid[$];

  adder_share_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid = N'(1 << id);
    rsp_ready = 1;
    #1;
    chk("grant", req_ready, 32'(1 << id));
    tick;
    req_valid = '0;
    chk("busy_calc", busy, 1);
    chk("no_rsp_calc", rsp_valid, 0);
    chk("no_ready_calc", req_ready, 0);
    tick;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_sum", rsp_sum, exp);
    chk("rsp_id", rsp_id, id);
    tick;
    chk("rsp_done", rsp_valid, 0);
    chk("idle", busy, 0);
  endtask

  task automatic probe_ptr(input logic [N-1:0] exp_grant, input string tag);
    req_valid = '1;
    #1;
    chk(tag, req_ready, exp_grant);
    req_valid = '0;
    tick;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 0;
    tick;
    tick;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    rst = 0;
    tick;
    chk("idle_no_req", req_ready, 0);
    // single op on requester 0, pointer moves to 1
    do_op(0, 6'd45, 6'd30, 6'd11);
    // sparse: only requester 3 with pointer at 1, pointer wraps to 0
    do_op(3, 6'd7, 6'd8, 6'd15);
    probe_ptr(4'b0001, "ptr_after_sparse");
    // carry discarded
    do_op(2, 6'd63, 6'd1, 6'd0);
    do_op(2, 6'd32, 6'd32, 6'd0);
    rst = 1;
    tick;
    rst = 0;
    tick;
    // round robin with everyone valid
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 6'(i + 1);
      req_b[i*W +: W] = 6'(10 * i);
    end
    req_valid = '1;
    rsp_ready = 1;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("onehot_ready", $countones(req_ready) <= 1, 1);
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          gcyc.push_back(c);
          gid.push_back(i);
        end
      if (c % 3 == 2) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (c / 3) % N);
        chk("rr_rsp_sum", rsp_sum, 11 * ((c / 3) % N) + 1);
      end
      tick;
    end
    req_valid = '0;
    chk("rr_grants", gid.size(), 5);
    for (int k = 0; k < gid.size(); k++) begin
      chk("rr_order", gid[k], k % N);
      chk("rr_spacing", gcyc[k], 3 * k);
    end
    tick;
    // backpressure: pointer is now 1
    rsp_ready = 0;
    req_a[1*W +: W] = 6'd10;
    req_b[1*W +: W] = 6'd20;
    req_valid = 4'b0010;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick;
    req_valid = '1;
    tick;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 30);
      chk("bp_id", rsp_id, 1);
      chk("bp_no_ready", req_ready, 0);
      tick;
    end
    rsp_ready = 1;
    req_valid = '0;
    chk("bp_last_valid", rsp_valid, 1);
    tick;
    chk("bp_done", rsp_valid, 0);
    probe_ptr(4'b0100, "ptr_after_bp");
    // reset during CALC abandons the op and clears the pointer
    req_a[3*W +: W] = 6'd5;
    req_b[3*W +: W] = 6'd5;
    req_valid = 4'b1000;
    #1;
    chk("mid_grant", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    chk("mid_calc_busy", busy, 1);
    rst = 1;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      chk("mid_no_rsp", rsp_valid, 0);
      chk("mid_idle", busy, 0);
      tick;
    end
    probe_ptr(4'b0001, "ptr_after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Time-shares one 6-bit ripple adder datapath (sum only, no carry-out, result modulo 2^WIDTH) between NUM_REQ independent requesters.
- A round-robin arbiter grants one requester at a time, latches its operands, drives the shared adder and registers the sum.
- The sum is returned through a valid/ready response channel tagged with the requester index.
- Sits between the requester blocks and the single adder instance; replaces per-requester adder copies.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 6, operand/sum width in bits; must match the shared adder.
- IDW, 2, width of requester index: clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  flattened operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester owning rsp_sum.
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at clock edge) sets state to IDLE, rr_ptr to 0, and operand latches, rsp_sum and rsp_id to 0. rsp_valid=0, req_ready=0, busy=0.
- Reset mid-operation abandons the transaction. No response is issued, and the granted requester is not re-served unless it re-asserts req_valid.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit at or after rr_ptr, searching upward and wrapping at NUM_REQ-1 back to 0.
  - req_ready[winner] is high combinationally in this cycle only. req_a/req_b of the winner and its index are latched. Next state is CALC.
  - If no req_valid is high, stay in IDLE with all req_ready=0.
- CALC: latched operands drive the shared adder. At the edge, rsp_sum <= adder sum and rsp_id <= latched index. Next state is RESP. Exactly one cycle, giving the ripple path a full clock period.
- RESP:
  - rsp_valid=1. rsp_sum and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid && rsp_ready: rr_ptr <= (winner+1) mod NUM_REQ, next state IDLE.
- Latency: accept at cycle N, rsp_valid at N+2. Minimum issue interval is 3 cycles.
- req_ready is never asserted outside IDLE. Requesters hold req_valid/operands until ready; a requester may drop req_valid without penalty.
- Arithmetic: unsigned, carry discarded, e.g. 63+1=0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- The pointer advances only on a completed response, not on grant.

Decomposition:
- Shared package adder_share_pkg: WIDTH localparam default, state typedef (IDLE/CALC/RESP), IDW helper function (clog2).
- One sub-module rr_arbiter (NUM_REQ): inputs req vector and rr_ptr, outputs one-hot grant, grant index and any_req. It is purely combinational.
- The FSM, latches and shared adder instance stay in the top module.

Test Plan:
- Single op: req_valid=4'b0001, a=45, b=30 -> req_ready[0] high one cycle, rsp_valid 2 cycles later with rsp_sum=11, rsp_id=0.
- Wrap: requester 2, a=63, b=1 -> rsp_sum=0, rsp_id=2; a=32, b=32 -> rsp_sum=0.
- Round-robin: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. Each grant is 3 cycles apart, and at most one req_ready bit is high in any cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable, no req_ready asserted. The response completes on the first rsp_ready=1 cycle.
- Reset mid-op: rst=1 during CALC -> next cycle state IDLE, rsp_valid never asserted for that op, busy=0, rr_ptr=0.
- Sparse requests: only req_valid[3] high with rr_ptr=1 -> requester 3 granted. rr_ptr becomes 0 after the response.
